sipo_frame: RTL and testbench
=============================

# sipo_frame

Parametrised serial-in/parallel-out deframer that succeeds the fixed 1024-bit enable-gated shift chain. It counts accepted serial bits, captures each complete WIDTH-bit frame into a holding register, and presents the frame on a valid/ready handshake so the downstream decoder can stall without corrupting data. Bit order is selectable. Overruns are flagged rather than silently lost.

## Interface
- WIDTH, 1024: frame length in bits; must be ≥ 2.
- MSB_FIRST, 1: 1 = first received bit lands in out[WIDTH-1] (legacy order); 0 = first received bit lands in out[0].
- CW, $clog2(WIDTH): bit-counter width (derived, not overridden).

Ports:
- clk  input  1  single clock; all state is updated on its rising edge.
- rnot  input  1  reset; asynchronous, active-low. Clears all state.
- clear  input  1  synchronous clear; active-high; same effect as reset.
- enable  input  1  serial strobe; `in` is accepted on every edge where enable=1.
- in  input  1  serial data bit.
- out  output  WIDTH  holding register containing the last completed frame.
- out_valid  output  1  out holds an unconsumed frame.
- out_ready  input  1  consumer accepts out on an edge where out_valid=1 and out_ready=1.
- bit_count  output  CW  number of bits already accepted in the current frame, 0..WIDTH-1.
- frame_done  output  1  one-cycle pulse; a frame completed on the previous edge, whether or not it was stored.
- overrun  output  1  sticky; a completed frame was dropped.

## Operation
- Reset (rnot=0) or clear=1: shift register, out, bit_count, out_valid, frame_done and overrun all go to 0. clear has priority over enable and out_ready.
- Accept (enable=1):
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], in}.
  - MSB_FIRST=0: sr <= {in, sr[WIDTH-1:1]}.
  - bit_count increments.
- enable=0: sr and bit_count hold.
- Completion: an accept while bit_count = WIDTH-1.
  - bit_count wraps to 0 and frame_done=1 on the next cycle.
  - The completed word is the shifted value including the current `in`.
- Holding register has two states, EMPTY (out_valid=0) and FULL (out_valid=1):
  - EMPTY + completion: load out, go to FULL.
  - FULL + out_ready, no completion: go to EMPTY; out keeps its value.
  - FULL + out_ready + completion in the same cycle: load the new word and stay FULL. This is not an overrun.
  - FULL + no out_ready + completion: out unchanged, new word dropped, overrun <= 1.
- overrun is cleared only by reset or clear.
- sr is never cleared on completion. The next frame overwrites it fully.

## Timing
- Last bit accepted at edge k → out, out_valid and frame_done are updated by edge k. They are visible in cycle k+1, i.e. one clock of latency.
- Consumer handshake: out_valid drops the edge after out_ready is sampled high, unless a new frame lands on that same edge.
- Throughput: one bit per clock. Back-to-back frames with enable held high are supported without gaps.
- Asynchronous reset takes effect immediately. A partial frame in progress is discarded.
- A frame in progress is unaffected by out_ready activity.
- out is stable whenever out_valid=1 and out_ready=0.

## Structure
- Shared package sipo_pkg holds:
  - the count-width function (clog2);
  - the holding-state encoding (EMPTY/FULL) as a typedef.
- One sub-module, shift_core: WIDTH-bit enable-gated shift register with MSB_FIRST direction parameter, async active-low reset (rnot) and synchronous clear.
- sipo_frame adds the counter, holding register, handshake and flags around shift_core.

## Test plan
All scenarios use WIDTH=8.
- Reset: rnot low mid-frame after 3 bits → out=0, bit_count=0, out_valid=0, overrun=0. The next 8 bits form a fresh frame.
- MSB_FIRST=1, shift in 1,0,1,1,0,0,1,0 with out_ready=1 → out=8'hB2, out_valid=1 for one cycle, frame_done single pulse.
- MSB_FIRST=0, same bit sequence → out=8'h4D.
- out_ready=0, two consecutive frames (8'hB2, then 8'hFF) → out stays 8'hB2, overrun=1 after frame 2. clear → all flags 0.
- Simultaneous case: out_valid=1 holding 8'hB2, out_ready=1 on the edge where frame 8'h0F completes → out=8'h0F, out_valid stays 1, overrun=0.
- enable toggling randomly over 8 accepted bits → bit_count tracks only accepted bits. Completion occurs exactly on the 8th accept, and the word matches a reference model.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in/parallel-out deframer:
// the counter-width helper and the holding-register state encoding.
package sipo_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } hold_state_t;

    // Smallest r with 2**r >= value; gives the bit-counter width for a frame length.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_core.sv
// Enable-gated WIDTH-bit shift register; exposes the value it would take on
// the next accepted bit so the framer can capture a word including that bit.
module shift_core #(
    parameter int WIDTH     = 1024,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rnot,
    input  logic             clear,
    input  logic             enable,
    input  logic             in,
    output logic [WIDTH-1:0] next_word
);

    logic [WIDTH-1:0] sr;

    always_comb begin
        next_word = MSB_FIRST ? {sr[WIDTH-2:0], in} : {in, sr[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rnot) begin
        if (!rnot) begin
            sr <= '0;
        end else if (clear) begin
            sr <= '0;
        end else if (enable) begin
            sr <= next_word;
        end
    end

endmodule

// File: rtl/sipo_frame.sv
// Serial deframer: counts accepted bits, captures each completed frame into a
// holding register and hands it downstream on a valid/ready handshake.
module sipo_frame
    import sipo_pkg::*;
#(
    parameter int  WIDTH     = 1024,
    parameter bit  MSB_FIRST = 1'b1,
    localparam int CW        = clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rnot,
    input  logic             clear,
    input  logic             enable,
    input  logic             in,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    bit_count,
    output logic             frame_done,
    output logic             overrun
);

    logic [WIDTH-1:0] next_word;
    logic             complete;
    logic             load;
    logic             drop;
    hold_state_t      state;
    hold_state_t      state_next;

    shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift_core (
        .clk       (clk),
        .rnot      (rnot),
        .clear     (clear),
        .enable    (enable),
        .in        (in),
        .next_word (next_word)
    );

    assign complete  = enable && (bit_count == CW'(WIDTH - 1));
    assign out_valid = (state == FULL);

    always_ff @(posedge clk or negedge rnot) begin
        if (!rnot) begin
            bit_count <= '0;
        end else if (clear) begin
            bit_count <= '0;
        end else if (enable) begin
            bit_count <= complete ? '0 : bit_count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rnot) begin
        if (!rnot) begin
            state <= EMPTY;
        end else if (clear) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // A completion coinciding with a consumer pop refills the register rather than overrunning.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        drop       = 1'b0;
        case (state)
            EMPTY: begin
                if (complete) begin
                    load       = 1'b1;
                    state_next = FULL;
                end
            end
            FULL: begin
                if (complete) begin
                    if (out_ready) begin
                        load = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end else if (out_ready) begin
                    state_next = EMPTY;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rnot) begin
        if (!rnot) begin
            out        <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else if (clear) begin
            out        <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_done <= complete;
            if (load) begin
                out <= next_word;
            end
            if (drop) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sipo_frame.sv
// Bench for sipo_frame at WIDTH=8: MSB-first and LSB-first instances share one
// stimulus stream; completed frames are predicted into a scoreboard queue.
module tb_sipo_frame;

    typedef struct packed {
        logic [7:0] msb;
        logic [7:0] lsb;
        logic       ovr;
    } exp_t;

    logic       clk;
    logic       rnot;
    logic       clear;
    logic       enable;
    logic       in_bit;
    logic       out_ready;

    logic [7:0] out_msb;
    logic       valid_msb;
    logic [2:0] count_msb;
    logic       done_msb;
    logic       ovr_msb;

    logic [7:0] out_lsb;
    logic       valid_lsb;
    logic [2:0] count_lsb;
    logic       done_lsb;
    logic       ovr_lsb;

    int         check_count = 0;
    int         pass_count  = 0;
    int         fail_count  = 0;

    exp_t       sb[$];
    int         m_count;
    logic [7:0] m_msb;
    logic [7:0] m_lsb;
    logic [7:0] m_out_msb;
    logic [7:0] m_out_lsb;
    logic       m_valid;
    logic       m_overrun;

    sipo_frame #(
        .WIDTH     (8),
        .MSB_FIRST (1'b1)
    ) dut_msb (
        .clk        (clk),
        .rnot       (rnot),
        .clear      (clear),
        .enable     (enable),
        .in         (in_bit),
        .out        (out_msb),
        .out_valid  (valid_msb),
        .out_ready  (out_ready),
        .bit_count  (count_msb),
        .frame_done (done_msb),
        .overrun    (ovr_msb)
    );

    sipo_frame #(
        .WIDTH     (8),
        .MSB_FIRST (1'b0)
    ) dut_lsb (
        .clk        (clk),
        .rnot       (rnot),
        .clear      (clear),
        .enable     (enable),
        .in         (in_bit),
        .out        (out_lsb),
        .out_valid  (valid_lsb),
        .out_ready  (out_ready),
        .bit_count  (count_lsb),
        .frame_done (done_lsb),
        .overrun    (ovr_lsb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count = check_count + 1;
        assert (observed === expected) pass_count = pass_count + 1;
        else begin
            fail_count = fail_count + 1;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        m_count   = 0;
        m_msb     = '0;
        m_lsb     = '0;
        m_out_msb = '0;
        m_out_lsb = '0;
        m_valid   = 1'b0;
        m_overrun = 1'b0;
        sb.delete();
    endtask

    task automatic checkCleared(input string tag);
        checkOutput({tag, "_out_msb"}, 32'(out_msb), 32'h0);
        checkOutput({tag, "_out_lsb"}, 32'(out_lsb), 32'h0);
        checkOutput({tag, "_count"}, 32'(count_msb), 32'h0);
        checkOutput({tag, "_valid"}, 32'(valid_msb), 32'h0);
        checkOutput({tag, "_done"}, 32'(done_lsb), 32'h0);
        checkOutput({tag, "_ovr"}, 32'(ovr_msb), 32'h0);
    endtask

    // One clock with the given inputs; the model predicts, the DUTs are compared after the edge.
    task automatic applyStimulus(input logic en, input logic b, input logic rdy);
        logic done_now;
        exp_t e;
        done_now = en && (m_count == 7);
        if (en) begin
            m_msb   = {m_msb[6:0], b};
            m_lsb   = {b, m_lsb[7:1]};
            m_count = done_now ? 0 : m_count + 1;
        end
        if (done_now) begin
            if (!m_valid || rdy) begin
                m_out_msb = m_msb;
                m_out_lsb = m_lsb;
                m_valid   = 1'b1;
            end else begin
                m_overrun = 1'b1;
            end
            e.msb = m_out_msb;
            e.lsb = m_out_lsb;
            e.ovr = m_overrun;
            sb.push_back(e);
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end

        enable    = en;
        in_bit    = b;
        out_ready = rdy;
        tick();

        checkOutput("count_msb", 32'(count_msb), 32'(m_count));
        checkOutput("count_lsb", 32'(count_lsb), 32'(m_count));
        checkOutput("done_msb", 32'(done_msb), 32'(done_now));
        checkOutput("done_lsb", 32'(done_lsb), 32'(done_now));
        checkOutput("valid_msb", 32'(valid_msb), 32'(m_valid));
        checkOutput("valid_lsb", 32'(valid_lsb), 32'(m_valid));
        if (done_now && sb.size() != 0) begin
            e = sb.pop_front();
            checkOutput("sb_out_msb", 32'(out_msb), 32'(e.msb));
            checkOutput("sb_out_lsb", 32'(out_lsb), 32'(e.lsb));
            checkOutput("sb_ovr_msb", 32'(ovr_msb), 32'(e.ovr));
            checkOutput("sb_ovr_lsb", 32'(ovr_lsb), 32'(e.ovr));
        end else begin
            checkOutput("hold_out_msb", 32'(out_msb), 32'(m_out_msb));
            checkOutput("hold_out_lsb", 32'(out_lsb), 32'(m_out_lsb));
            checkOutput("hold_ovr", 32'(ovr_msb), 32'(m_overrun));
        end
    endtask

    // Bits are sent bits[7] first; out_ready may differ on the completing bit.
    task automatic applyFrame(input logic [7:0] bits, input logic rdy_early,
                              input logic rdy_last);
        for (int i = 7; i >= 0; i--) begin
            applyStimulus(1'b1, bits[i], (i == 0) ? rdy_last : rdy_early);
        end
    endtask

    task automatic applyClear();
        clear     = 1'b1;
        enable    = 1'b1;
        in_bit    = 1'b1;
        out_ready = 1'b1;
        tick();
        clear     = 1'b0;
        enable    = 1'b0;
        out_ready = 1'b0;
        modelReset();
        checkCleared("clear");
    endtask

    initial begin
        rnot      = 1'b0;
        clear     = 1'b0;
        enable    = 1'b0;
        in_bit    = 1'b0;
        out_ready = 1'b0;
        modelReset();
        #12;
        checkCleared("reset");
        rnot = 1'b1;
        tick();

        $display("[TB] MSB/LSB first frame with consumer ready");
        applyFrame(8'b1011_0010, 1'b1, 1'b1);
        checkOutput("word_msb_B2", 32'(out_msb), 32'hB2);
        checkOutput("word_lsb_4D", 32'(out_lsb), 32'h4D);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);

        $display("[TB] async reset mid-frame");
        applyFrame(8'b1011_0010, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        #2;
        rnot = 1'b0;
        #1;
        checkCleared("async_reset");
        tick();
        rnot = 1'b1;
        modelReset();
        applyFrame(8'b0000_1111, 1'b0, 1'b0);
        checkOutput("fresh_word_0F", 32'(out_msb), 32'h0F);

        $display("[TB] back-to-back frames with stalled consumer");
        applyClear();
        applyFrame(8'b1011_0010, 1'b0, 1'b0);
        applyFrame(8'b1111_1111, 1'b0, 1'b0);
        checkOutput("ovr_keep_B2", 32'(out_msb), 32'hB2);
        checkOutput("ovr_flag", 32'(ovr_msb), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyClear();

        $display("[TB] completion coincides with consumer pop");
        applyFrame(8'b1011_0010, 1'b0, 1'b0);
        applyFrame(8'b0000_1111, 1'b0, 1'b1);
        checkOutput("simul_word_0F", 32'(out_msb), 32'h0F);
        checkOutput("simul_valid", 32'(valid_msb), 32'h1);
        checkOutput("simul_ovr", 32'(ovr_lsb), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("drain_keep_0F", 32'(out_msb), 32'h0F);

        $display("[TB] random enable over one frame");
        applyClear();
        begin
            int accepts;
            logic en;
            accepts = 0;
            for (int c = 0; c < 200 && accepts < 8; c++) begin
                en = (c >= 150) ? 1'b1 : 1'($urandom_range(0, 1));
                applyStimulus(en, 1'($urandom_range(0, 1)), 1'b1);
                if (en) accepts = accepts + 1;
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
